// File: rtl/vga_pkg.sv
// Shared VGA mode constants and lock-state encoding for the timing generator and receiver.
package vga_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned MM_W  = 16;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned RGB_W = 3;

    // Default 640x480@60 mode
    localparam int unsigned VGA_H_ACTIVE     = 640;
    localparam int unsigned VGA_H_SYNC_START = 656;
    localparam int unsigned VGA_H_SYNC_W     = 96;
    localparam int unsigned VGA_H_TOTAL      = 800;
    localparam int unsigned VGA_V_ACTIVE     = 480;
    localparam int unsigned VGA_V_SYNC_START = 490;
    localparam int unsigned VGA_V_SYNC_W     = 2;
    localparam int unsigned VGA_V_TOTAL      = 525;
    localparam logic [RGB_W-1:0] VGA_EXPECT_RGB = 3'b011;

    typedef enum logic [1:0] {
        SEARCH,
        ALIGN,
        LOCKED
    } lock_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Previous-value register, fall/rise detection and low-width counter for one active-low sync line.
module vga_sync_edge
    import vga_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sync,
    input  logic         cnt_en,
    output logic         fall_c,
    output logic         rise_c,
    output logic [W-1:0] low_cnt
);

    logic sync_prev;

    assign fall_c = sync_prev & ~sync;
    assign rise_c = ~sync_prev & sync;

    // Counts cnt_en qualifiers while low, including the falling-edge sample; saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_prev <= 1'b1;
            low_cnt   <= '0;
        end else begin
            sync_prev <= sync;
            if (fall_c) begin
                low_cnt <= W'(cnt_en);
            end else if (!sync && cnt_en && (low_cnt != '1)) begin
                low_cnt <= low_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_receiver.sv
// Sink-side VGA monitor: recovers pixel coordinates, checks sync timing, tracks lock
// and counts per-frame colour mismatches against an expected fill colour.
module vga_timing_receiver
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned H_SYNC_W     = VGA_H_SYNC_W,
    parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned V_SYNC_W     = VGA_V_SYNC_W,
    parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
    parameter logic [RGB_W-1:0] EXPECT_RGB = VGA_EXPECT_RGB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic [RGB_W-1:0] rgb,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             de,
    output logic [RGB_W-1:0] rgb_out,
    output logic             locked,
    output logic             frame_done,
    output logic             timing_err,
    output logic [ERR_W-1:0] err_count,
    output logic [MM_W-1:0]  frame_mismatch
);

    localparam logic [CNT_W-1:0] X_ACT       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] X_SYNC      = CNT_W'(H_SYNC_START);
    localparam logic [CNT_W-1:0] X_SYNC_NEXT = CNT_W'(H_SYNC_START + 1);
    localparam logic [CNT_W-1:0] X_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_TOTAL     = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] H_W         = CNT_W'(H_SYNC_W);
    localparam logic [CNT_W-1:0] Y_ACT       = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] Y_SYNC      = CNT_W'(V_SYNC_START);
    localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_TOTAL     = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] V_W         = CNT_W'(V_SYNC_W);

    logic             h_fall, h_rise, v_fall, v_rise;
    logic [CNT_W-1:0] h_low, v_low;
    logic [CNT_W-1:0] x_cnt, y_cnt, line_len, v_lines;
    logic             line_seen;
    logic [MM_W-1:0]  mm_acc;
    lock_state_t      state, state_next;

    logic [CNT_W-1:0] cur_x, cur_y, x_next, y_next;
    logic             x_wrap, err_c, active_c, de_c, frame_done_c, mm_hit_c;

    vga_sync_edge #(.W(CNT_W)) u_h_edge (
        .clk    (clk),
        .reset  (reset),
        .sync   (h_sync),
        .cnt_en (1'b1),
        .fall_c (h_fall),
        .rise_c (h_rise),
        .low_cnt(h_low)
    );

    // v-low width is measured in lines, i.e. h_sync falling edges.
    vga_sync_edge #(.W(CNT_W)) u_v_edge (
        .clk    (clk),
        .reset  (reset),
        .sync   (v_sync),
        .cnt_en (h_fall),
        .fall_c (v_fall),
        .rise_c (v_rise),
        .low_cnt(v_low)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= SEARCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        cur_x        = h_fall ? X_SYNC : x_cnt;
        cur_y        = v_fall ? Y_SYNC : y_cnt;
        x_wrap       = !h_fall && (x_cnt == X_LAST);
        x_next       = x_cnt + 1'b1;
        y_next       = y_cnt;
        err_c        = 1'b0;
        active_c     = (cur_x < X_ACT) && (cur_y < Y_ACT);
        de_c         = 1'b0;
        frame_done_c = 1'b0;
        mm_hit_c     = 1'b0;

        if (h_fall)      x_next = X_SYNC_NEXT;
        else if (x_wrap) x_next = '0;

        // A v_fall realigns y even when x wraps on the same sample.
        if (v_fall)      y_next = Y_SYNC;
        else if (x_wrap) y_next = (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;

        if (h_fall && line_seen && (line_len != X_TOTAL))      err_c = 1'b1;
        if (h_rise && (h_low != H_W))                          err_c = 1'b1;
        if (v_fall && (state != SEARCH) && (v_lines != Y_TOTAL)) err_c = 1'b1;
        if (v_rise && (v_low != V_W))                          err_c = 1'b1;

        case (state)
            SEARCH: if (v_fall && !err_c) state_next = ALIGN;
            ALIGN: begin
                if (err_c)       state_next = SEARCH;
                else if (v_fall) state_next = LOCKED;
            end
            LOCKED: if (err_c) state_next = SEARCH;
            default: state_next = SEARCH;
        endcase

        frame_done_c = (state == LOCKED) && v_fall && !err_c;
        mm_hit_c     = (state == LOCKED) && active_c && (rgb != EXPECT_RGB);
        de_c         = (state_next == LOCKED) && active_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt          <= '0;
            y_cnt          <= '0;
            line_len       <= '0;
            v_lines        <= '0;
            line_seen      <= 1'b0;
            mm_acc         <= '0;
            pixel_x        <= '0;
            pixel_y        <= '0;
            de             <= 1'b0;
            rgb_out        <= '0;
            locked         <= 1'b0;
            frame_done     <= 1'b0;
            timing_err     <= 1'b0;
            err_count      <= '0;
            frame_mismatch <= '0;
        end else begin
            x_cnt <= x_next;
            y_cnt <= y_next;

            if (h_fall)               line_len <= CNT_W'(1);
            else if (line_len != '1)  line_len <= line_len + 1'b1;
            if (h_fall)               line_seen <= 1'b1;

            if (v_fall)                         v_lines <= CNT_W'(h_fall);
            else if (h_fall && (v_lines != '1)) v_lines <= v_lines + 1'b1;

            // Accumulator restarts on each published frame and whenever lock is lost.
            if ((state_next == SEARCH) || frame_done_c) mm_acc <= '0;
            else if (mm_hit_c && (mm_acc != '1))       mm_acc <= mm_acc + 1'b1;
            if (frame_done_c) frame_mismatch <= mm_acc;

            if ((state == LOCKED) && err_c && (err_count != '1)) err_count <= err_count + 1'b1;

            pixel_x    <= cur_x;
            pixel_y    <= cur_y;
            de         <= de_c;
            rgb_out    <= de_c ? rgb : '0;
            locked     <= (state_next == LOCKED);
            frame_done <= frame_done_c;
            timing_err <= err_c;
        end
    end

endmodule
